// File: rtl/mult_three_tx.sv
// ---------------------------------------------------------------------------
// mult_three_tx
//
// Serialises a WIDTH-bit word MSB first. Alongside the bits it tracks the
// running residue mod 3 of the transmitted value. That residue gives a
// downstream mod-3 checker a golden divisible-by-3 flag on the final bit.
// A one-cycle ser_clr pulse precedes every frame so the checker starts from
// zero.
//
// Optional feature (macro MULT_THREE_PAD_EN):
//   Two pad bits k[1:0] follow the data bits, where k = (3 - data mod 3) mod 3.
//   The transmitted value 4*data + k is then always a multiple of 3. The
//   frame grows to WIDTH+2 bits, and ser_last/exp_div3 move to the last pad
//   bit. With the macro undefined there is no PAD state, and a frame is
//   exactly WIDTH bits.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   in_data   in   [WIDTH-1:0] word to transmit
//   in_valid  in   in_data valid (sampled only in IDLE)
//   in_ready  out  high in IDLE: a word can be accepted
//   ser_clr   out  one-cycle clear pulse for the downstream checker
//   ser_out   out  serial data bit, MSB first (0 when not valid)
//   ser_valid out  ser_out carries a frame bit
//   ser_last  out  final bit of the frame
//   exp_div3  out  expected divisibility by 3, qualified by ser_last
//   busy      out  frame in progress
// ---------------------------------------------------------------------------
module mult_three_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_clr,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             exp_div3,
  output logic             busy
);

  // The bit counter must reach WIDTH+1 when the pad bits are enabled.
  localparam int CW = $clog2(WIDTH + 2);

`ifdef MULT_THREE_PAD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CLR = 2'd1, SHIFT = 2'd2, PAD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CLR = 2'd1, SHIFT = 2'd2} state_t;
`endif

  state_t         state;
  state_t         nextState;
  logic [WIDTH-1:0] shiftReg;
  logic [1:0]     residue;
  logic [1:0]     residueNext;
  logic [CW-1:0]  bitCnt;
  logic           curBit;
  logic           lastDataBit;
  logic           accept;
`ifdef MULT_THREE_PAD_EN
  logic [1:0]     padBits;
  logic           lastPadBit;
`endif

  // r' = (2r + b) mod 3
  function automatic logic [1:0] mod3Step(input logic [1:0] r, input logic b);
    logic [1:0] res;
    res = 2'd0;
    case (r)
      2'd0:    res = b ? 2'd1 : 2'd0;
      2'd1:    res = b ? 2'd0 : 2'd2;
      2'd2:    res = b ? 2'd2 : 2'd1;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  assign accept      = in_valid && (state == IDLE);
  assign lastDataBit = (bitCnt == CW'(WIDTH - 1));

`ifdef MULT_THREE_PAD_EN
  assign lastPadBit  = (state == PAD) && (bitCnt == CW'(WIDTH + 1));
  assign curBit      = (state == PAD) ? padBits[1] : shiftReg[WIDTH-1];
`else
  assign curBit      = shiftReg[WIDTH-1];
`endif

  // The residue including the bit on the wire this cycle. It is derived only
  // from registers, so the outputs stay Moore-style.
  assign residueNext = mod3Step(residue, curBit);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Datapath registers. The word is latched on accept and shifted once per
  // data bit. The residue folds in every transmitted bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shiftReg <= '0;
      residue  <= 2'd0;
      bitCnt   <= '0;
`ifdef MULT_THREE_PAD_EN
      padBits  <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shiftReg <= in_data;
            residue  <= 2'd0;
            bitCnt   <= '0;
          end
        end
        SHIFT: begin
          shiftReg <= shiftReg << 1;
          residue  <= residueNext;
          bitCnt   <= bitCnt + CW'(1);
`ifdef MULT_THREE_PAD_EN
          // After the last data bit, the residue equals data mod 3. The pad
          // is the amount that brings 4*data + k back to 0 mod 3.
          if (lastDataBit) begin
            case (residueNext)
              2'd1:    padBits <= 2'd2;
              2'd2:    padBits <= 2'd1;
              default: padBits <= 2'd0;
            endcase
          end
`endif
        end
`ifdef MULT_THREE_PAD_EN
        PAD: begin
          padBits <= {padBits[0], 1'b0};
          residue <= residueNext;
          bitCnt  <= bitCnt + CW'(1);
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and output decoding from the registered state
  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    ser_clr   = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
    exp_div3  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          nextState = CLR;
        end
      end
      CLR: begin
        ser_clr   = 1'b1;
        nextState = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = curBit;
`ifdef MULT_THREE_PAD_EN
        if (lastDataBit) begin
          nextState = PAD;
        end
`else
        ser_last = lastDataBit;
        exp_div3 = lastDataBit && (residueNext == 2'd0);
        if (lastDataBit) begin
          nextState = IDLE;
        end
`endif
      end
`ifdef MULT_THREE_PAD_EN
      PAD: begin
        ser_valid = 1'b1;
        ser_out   = curBit;
        ser_last  = lastPadBit;
        exp_div3  = lastPadBit;
        if (lastPadBit) begin
          nextState = IDLE;
        end
      end
`endif
      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_three_tx.sv
// ---------------------------------------------------------------------------
// tb_mult_three_tx
//
// Directed bench for mult_three_tx with WIDTH=8. The stimulus process pushes
// hand-computed expected frames into a queue. A separate monitor assembles
// the serial bits between ser_clr and ser_last, and pops and compares them.
// The monitor also runs a small mod-3 checker, cleared by ser_clr, as an
// independent reference for exp_div3. Define MULT_THREE_PAD_EN to exercise
// the padded build.
// ---------------------------------------------------------------------------
module tb_mult_three_tx;

  localparam int WIDTH = 8;
`ifdef MULT_THREE_PAD_EN
  localparam int FRAME_BITS = WIDTH + 2;
`else
  localparam int FRAME_BITS = WIDTH;
`endif

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_clr;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             exp_div3;
  logic             busy;

  typedef struct {
    logic [WIDTH+1:0] bits;
    int               nbits;
    logic             div3;
  } frame_t;

  frame_t expQ[$];
  int     checks = 0;
  int     errors = 0;

  mult_three_tx #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_clr  (ser_clr),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_last (ser_last),
    .exp_div3 (exp_div3),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // k is the hand-computed pad for the word; div3 is data%3==0 for the
  // unpadded build.
  task automatic pushExpected(input logic [WIDTH-1:0] d, input logic [1:0] k, input logic div3);
    frame_t f;
`ifdef MULT_THREE_PAD_EN
    f.bits  = {d, k};
    f.nbits = WIDTH + 2;
    f.div3  = 1'b1;
`else
    f.bits  = {2'b00, d};
    f.nbits = WIDTH;
    f.div3  = div3;
    if (k == 2'd3) f.div3 = div3;
`endif
    expQ.push_back(f);
  endtask

  // Waits (bounded) for in_ready at a falling edge, then presents one word
  // for a single rising edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [1:0] k,
                               input logic div3, input logic doPush);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 32'(in_ready), 32'd1);
    end else begin
      in_data  = d;
      in_valid = 1'b1;
      if (doPush) pushExpected(d, k, div3);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
    end
  endtask

  // Monitor: assemble frames, compare against the scoreboard and the mod-3
  // checker, and confirm handshake timing around ser_clr and ser_last.
  initial begin
    logic [WIDTH+1:0] col;
    int               nb;
    logic [1:0]       modR;
    logic             readyChk;
    logic             lastWasClr;
    frame_t           f;
    col = '0; nb = 0; modR = 2'd0; readyChk = 1'b0; lastWasClr = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        col = '0; nb = 0; modR = 2'd0; readyChk = 1'b0; lastWasClr = 1'b0;
      end else begin
        if (readyChk) begin
          checkOutput("readyAfterLast", 32'(in_ready), 32'd1);
          readyChk = 1'b0;
        end
        if (ser_clr) begin
          checkOutput("clrNoValid", 32'(ser_valid), 32'd0);
          col = '0; nb = 0; modR = 2'd0;
        end
        if (ser_valid) begin
          if (nb == 0) checkOutput("firstBitAfterClr", 32'(lastWasClr), 32'd1);
          col  = {col[WIDTH:0], ser_out};
          nb++;
          case (modR)
            2'd0:    modR = ser_out ? 2'd1 : 2'd0;
            2'd1:    modR = ser_out ? 2'd0 : 2'd2;
            default: modR = ser_out ? 2'd2 : 2'd1;
          endcase
          if (ser_last) begin
            checkOutput("readyLowOnLast", 32'(in_ready), 32'd0);
            checkOutput("checkerVsExpDiv3", 32'(exp_div3), 32'(modR == 2'd0));
            if (expQ.size() == 0) begin
              checkOutput("unexpectedFrame", 32'(expQ.size()), 32'd1);
            end else begin
              f = expQ.pop_front();
              checkOutput("frameBitCount", 32'(nb), 32'(f.nbits));
              checkOutput("frameBits", 32'(col), 32'(f.bits));
              checkOutput("frameExpDiv3", 32'(exp_div3), 32'(f.div3));
            end
            readyChk = 1'b1;
            nb = 0;
          end else begin
            checkOutput("expDiv3LowMidFrame", 32'(exp_div3), 32'd0);
          end
        end
        lastWasClr = ser_clr;
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    int cnt;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetInReady", 32'(in_ready), 32'd1);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetSerValid", 32'(ser_valid), 32'd0);
    checkOutput("resetSerClr", 32'(ser_clr), 32'd0);
    checkOutput("resetSerOut", 32'(ser_out), 32'd0);
    checkOutput("resetSerLast", 32'(ser_last), 32'd0);
    checkOutput("resetExpDiv3", 32'(exp_div3), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] basic words 0x06 and 0x07");
    applyStimulus(8'h06, 2'd0, 1'b1, 1'b1);
    applyStimulus(8'h07, 2'd2, 1'b0, 1'b1);

    // Hold in_valid high with junk data through a whole frame; only the
    // word present when in_ready returns may be taken.
    $display("[TB] in_valid held high across a frame");
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_data  = 8'h0A;
    in_valid = 1'b1;
    pushExpected(8'h0A, 2'd2, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!in_ready) in_data = WIDTH'($urandom);
    end while (!in_ready && n < 100);
    checkOutput("acceptSpacing", 32'(n), 32'(FRAME_BITS + 2));
    in_data = 8'h80;
    pushExpected(8'h80, 2'd1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;

    // Reset on the 4th bit of 0xFF, then a clean 0x03
    $display("[TB] reset mid-frame");
    applyStimulus(8'hFF, 2'd0, 1'b1, 1'b0);
    cnt = 0;
    n   = 0;
    while (cnt < 3 && n < 50) begin
      @(negedge clk);
      #1;
      if (ser_valid) cnt++;
      n++;
    end
    checkOutput("bitsBeforeReset", 32'(cnt), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abortSerValid", 32'(ser_valid), 32'd0);
    checkOutput("abortInReady", 32'(in_ready), 32'd1);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortSerLast", 32'(ser_last), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    #1;
    checkOutput("noAcceptInReset", 32'(busy), 32'd0);
    in_valid = 1'b0;
    in_data  = '0;
    reset    = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("idleAfterReset", 32'(ser_valid | ser_clr | busy), 32'd0);
    applyStimulus(8'h03, 2'd0, 1'b1, 1'b1);

    $display("[TB] zero and all-ones words");
    applyStimulus(8'h00, 2'd0, 1'b1, 1'b1);
    applyStimulus(8'hFF, 2'd0, 1'b1, 1'b1);
    applyStimulus(8'h09, 2'd0, 1'b1, 1'b1);

    n = 0;
    while (expQ.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
